hazard_scoreboard: RTL

Parametrised decode-stage hazard unit; successor to the fixed load-use stall logic.
- Keeps a per-register countdown scoreboard of results not yet forwardable; stalls decode while any used source is pending.
- Supports per-instruction result latency, pipeline freeze (memory busy) and branch flush of young producers.
- Sits between decode and issue; drives stallD and a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_sb_entry.sv | 46 ++++
 rtl/hazard_scoreboard.sv | 80 ++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared defaults, latency classes and counter sizing for the decode hazard scoreboard.
package hazard_pkg;

    localparam int unsigned DEF_NUM_REGS = 8;
    localparam int unsigned DEF_REG_W    = 3;
    localparam int unsigned DEF_MAX_LAT  = 3;

    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 1;
    localparam int unsigned LAT_MUL  = DEF_MAX_LAT;

    // Countdown width; kept at least one bit so MAX_LAT=0 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: countdown until the register's result is forwardable.
module hazard_sb_entry
    import hazard_pkg::*;
#(
    parameter int unsigned CW          = 2,
    parameter int unsigned FLUSH_DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_freeze,
    input  logic          i_flush,
    input  logic          i_load,
    input  logic [CW-1:0] i_lat,
    output logic          o_busy
);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_lat;
    logic [CW-1:0] w_age;
    logic          w_young;

    assign w_age   = r_lat - r_cnt;
    assign w_young = (r_cnt != '0) && (32'(w_age) < FLUSH_DEPTH);
    assign o_busy  = (r_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_lat <= '0;
        end else if (i_flush) begin
            // Young producers are squashed; older ones keep ageing unless frozen.
            if (w_young)
                r_cnt <= '0;
            else if (!i_freeze && (r_cnt != '0))
                r_cnt <= r_cnt - CW'(1);
        end else if (!i_freeze) begin
            if (i_load) begin
                r_cnt <= i_lat;
                r_lat <= i_lat;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register countdown scoreboard, stall/issue and stall statistics.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
    parameter int unsigned REG_W       = DEF_REG_W,
    parameter int unsigned MAX_LAT     = DEF_MAX_LAT,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned STAT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic                          id_use_rs1,
    input  logic                          id_use_rs2,
    input  logic [REG_W-1:0]              rsrc1,
    input  logic [REG_W-1:0]              rsrc2,
    input  logic                          id_wr,
    input  logic [REG_W-1:0]              rdst,
    input  logic [cnt_width(MAX_LAT)-1:0] id_lat,
    input  logic                          freeze,
    input  logic                          flush,
    output logic                          stallD,
    output logic                          issue,
    output logic [NUM_REGS-1:0]           pending,
    output logic [STAT_W-1:0]             stall_cycles
);

    localparam int unsigned CW = cnt_width(MAX_LAT);

    logic [NUM_REGS-1:0] w_load;
    logic [CW-1:0]       w_lat;
    logic                w_busy1;
    logic                w_busy2;
    logic                w_haz;
    logic [STAT_W-1:0]   r_stall;

    // Indices with no matching slot read as not busy.
    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rsrc1 == REG_W'(i)) w_busy1 = pending[i];
            if (rsrc2 == REG_W'(i)) w_busy2 = pending[i];
        end
    end

    assign w_haz  = id_valid & ((id_use_rs1 & w_busy1) | (id_use_rs2 & w_busy2));
    assign stallD = w_haz & ~flush;
    assign issue  = id_valid & ~w_haz & ~freeze & ~flush;
    assign w_lat  = (32'(id_lat) > MAX_LAT) ? CW'(MAX_LAT) : id_lat;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
        assign w_load[g] = issue & id_wr & (rdst == REG_W'(g));

        hazard_sb_entry #(
            .CW          (CW),
            .FLUSH_DEPTH (FLUSH_DEPTH)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_freeze (freeze),
            .i_flush  (flush),
            .i_load   (w_load[g]),
            .i_lat    (w_lat),
            .o_busy   (pending[g])
        );
    end

    // Frozen cycles still show stallD but are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall <= '0;
        else if (stallD && !freeze && (r_stall != '1))
            r_stall <= r_stall + STAT_W'(1);
    end

    assign stall_cycles = r_stall;

endmodule
